// File: rtl/spi_slave_if.sv
// spi_slave_if: serial front end between the SPI pins and the single-port RAM.
//
// Deserialises 10-bit command frames from MOSI (MSB first) into rx_data with a
// one-cycle rx_valid strobe. For read-data frames it waits for the RAM's byte
// on tx_data/tx_valid and shifts it out on MISO, MSB first.
//
// Ports:
//   clk       system clock, everything happens on the rising edge
//   rst_n     asynchronous active-low reset
//   SS_n      slave select, active low; high marks a frame boundary
//   MOSI      serial command/data in
//   MISO      serial read data out (0 when idle)
//   rx_data   assembled command word; [9:8] command, [7:0] payload
//   rx_valid  one-cycle strobe qualifying rx_data
//   tx_data   read byte from the RAM
//   tx_valid  one-cycle strobe qualifying tx_data
//
// Optional feature macro: SPI_SLAVE_RD_SEQ_EN
//   When defined, read frames must alternate address (bit 8 = 0) then data
//   (bit 8 = 1), tracked by an internal rd_addr_done flag; out-of-sequence
//   read frames are dropped silently. When undefined, every frame is
//   forwarded and any word with [9:8] = 2'b11 starts the MISO phase.
module spi_slave_if #(
  parameter int unsigned FRAME_W = 10,
  parameter int unsigned DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int unsigned TxCntW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_t;

  state_t              r_state;
  logic [3:0]          r_bit_cnt;    // frame bits captured so far
  logic [FRAME_W-2:0]  r_frame;      // bits captured before the current one
  logic                r_frame_done; // frame complete; ignore MOSI until SS_n high
  logic                r_tx_wait;    // READ_DATA waiting for tx_valid
  logic [DATA_W-1:0]   r_tx_shift;
  logic [TxCntW-1:0]   r_tx_cnt;     // MISO bits still to send
`ifdef SPI_SLAVE_RD_SEQ_EN
  logic                r_rd_addr_done;
`endif

  logic [FRAME_W-1:0]  w_word;
  logic                w_last;
  logic                w_seq_ok;
  logic                w_enter_tx;

  // Full word as it will be once the bit on MOSI is captured this edge.
  assign w_word = {r_frame, MOSI};
  assign w_last = (r_bit_cnt == 4'(FRAME_W - 1));

`ifdef SPI_SLAVE_RD_SEQ_EN
  // Address reads carry bit 8 = 0, data reads bit 8 = 1.
  assign w_seq_ok   = (r_state == StReadAdd)  ? !w_word[FRAME_W-2] :
                      (r_state == StReadData) ?  w_word[FRAME_W-2] : 1'b1;
  assign w_enter_tx = (r_state == StReadData);
`else
  assign w_seq_ok   = 1'b1;
  assign w_enter_tx = (w_word[FRAME_W-1 -: 2] == 2'b11);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_bit_cnt      <= '0;
      r_frame        <= '0;
      r_frame_done   <= 1'b0;
      r_tx_wait      <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      MISO           <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
`ifdef SPI_SLAVE_RD_SEQ_EN
      r_rd_addr_done <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        // Frame boundary: drop any partial frame or unfinished MISO byte.
        r_state      <= StIdle;
        r_bit_cnt    <= '0;
        r_frame_done <= 1'b0;
        r_tx_wait    <= 1'b0;
        r_tx_cnt     <= '0;
        MISO         <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            r_state <= StChkCmd;
          end

          StChkCmd: begin
            r_frame   <= {{(FRAME_W-2){1'b0}}, MOSI};
            r_bit_cnt <= 4'd1;
            if (!MOSI) begin
              r_state <= StWrite;
            end else begin
`ifdef SPI_SLAVE_RD_SEQ_EN
              r_state <= r_rd_addr_done ? StReadData : StReadAdd;
`else
              r_state <= StReadAdd;
`endif
            end
          end

          StWrite, StReadAdd, StReadData: begin
            if (!r_frame_done) begin
              r_frame   <= w_word[FRAME_W-2:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_last) begin
                r_frame_done <= 1'b1;
                if (w_seq_ok) begin
                  rx_data  <= w_word;
                  rx_valid <= 1'b1;
`ifdef SPI_SLAVE_RD_SEQ_EN
                  if (r_state == StReadAdd)  r_rd_addr_done <= 1'b1;
                  if (r_state == StReadData) r_rd_addr_done <= 1'b0;
`endif
                  if (w_enter_tx) begin
                    r_state   <= StReadData;
                    r_tx_wait <= 1'b1;
                  end
                end
              end
            end else if (r_tx_wait && tx_valid) begin
              r_tx_wait  <= 1'b0;
              r_tx_shift <= tx_data;
              r_tx_cnt   <= TxCntW'(DATA_W);
            end else if (r_tx_cnt != '0) begin
              MISO       <= r_tx_shift[DATA_W-1];
              r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
              r_tx_cnt   <= r_tx_cnt - 1'b1;
            end else begin
              MISO <= 1'b0;
            end
          end

          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if. Expected command words and MISO bits
// are queued when stimulus is driven and compared when the DUT produces them.
module tb_spi_slave_if;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               SS_n = 1'b1;
  logic               MOSI = 1'b0;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data = '0;
  logic               tx_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [FRAME_W-1:0] rx_q[$];
  logic               miso_q[$];
  logic               prev_rxv = 1'b0;

  spi_slave_if #(.FRAME_W(FRAME_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every rx_valid must match the oldest queued word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (prev_rxv) begin
          checks++; errors++;
          $display("FAIL rx_valid_consecutive: got 1 for two cycles, required single pulse");
        end
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rx_valid: got rx_valid with rx_data=%h, required none", rx_data);
        end else begin
          logic [FRAME_W-1:0] exp;
          exp = rx_q.pop_front();
          if (rx_data !== exp) begin
            errors++;
            $display("FAIL rx_data: got %h required %h", rx_data, exp);
          end
        end
      end
      prev_rxv = rx_valid;
    end
  end

  // Drops SS_n, then presents nbits of w MSB first, one per clock. Returns on
  // the negedge where the last bit is on MOSI (sampled on the next rising edge).
  task automatic send_bits(input logic [FRAME_W-1:0] w, input int nbits);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      MOSI = w[FRAME_W-1-i];
    end
  endtask

  task automatic close_frame;
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b required 0", MISO); end
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %h required 000", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write;
    logic [FRAME_W-1:0] frames [2];
    frames[0] = 10'h0A5;
    frames[1] = 10'h13C;
    for (int f = 0; f < 2; f++) begin
      rx_q.push_back(frames[f]);
      send_bits(frames[f], FRAME_W);
      checks++;
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL write_early_valid: got %b required 0", rx_valid); end
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1) begin errors++; $display("FAIL write_valid_at_11: got %b required 1", rx_valid); end
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL write_valid_pulse: got %b required 0", rx_valid); end
      close_frame();
    end
  endtask

  task automatic test_reset_mid_frame;
    send_bits(10'h2F0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL midrst_rx_data: got %h required 000", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_rx_valid: got %b required 0", rx_valid); end
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %b required 0", MISO); end
    @(negedge clk);
    rst_n = 1'b1;
    close_frame();
    rx_q.push_back(10'h0C3);
    send_bits(10'h0C3, FRAME_W);
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL midrst_next_frame: got %b required 1", rx_valid); end
    close_frame();
  endtask

  task automatic test_read_seq;
    logic [DATA_W-1:0] rd_byte;
    rd_byte = 8'hC3;
    rx_q.push_back(10'h2A5);
    send_bits(10'h2A5, FRAME_W);
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL read_addr_valid: got %b required 1", rx_valid); end
    close_frame();

    rx_q.push_back(10'h300);
    send_bits(10'h300, FRAME_W);
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL read_data_valid: got %b required 1", rx_valid); end
    @(negedge clk);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = rd_byte;
    for (int i = DATA_W - 1; i >= 0; i--) miso_q.push_back(rd_byte[i]);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = '0;
    checks++;
    if (MISO !== 1'b0) begin errors++; $display("FAIL miso_before_first: got %b required 0", MISO); end
    for (int i = 0; i < DATA_W; i++) begin
      logic exp_b;
      @(negedge clk);
      exp_b = miso_q.pop_front();
      checks++;
      if (MISO !== exp_b) begin errors++; $display("FAIL miso_bit%0d: got %b required %b", i, MISO, exp_b); end
    end
    @(negedge clk);
    checks++;
    if (MISO !== 1'b0) begin errors++; $display("FAIL miso_after_byte: got %b required 0", MISO); end
    close_frame();
  endtask

  task automatic test_abort;
    logic [FRAME_W-1:0] held;
    held = 10'h300;
    send_bits(10'h155, 6);
    @(negedge clk);
    // One clock with SS_n high, then straight into the next frame.
    SS_n = 1'b1;
    rx_q.push_back(10'h0A5);
    send_bits(10'h0A5, FRAME_W);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %b required 0", rx_valid); end
    checks++;
    if (rx_data !== held) begin errors++; $display("FAIL abort_rx_data_held: got %h required %h", rx_data, held); end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL abort_next_frame: got %b required 1", rx_valid); end
    close_frame();
  endtask

  task automatic test_stray_tx;
    logic miso_seen;
    logic [FRAME_W-1:0] w;
    miso_seen = 1'b0;
    w = 10'h0FF;
    rx_q.push_back(w);
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < FRAME_W; i++) begin
      @(negedge clk);
      miso_seen |= MISO;
      MOSI = w[FRAME_W-1-i];
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
    end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL stray_write_valid: got %b required 1", rx_valid); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      miso_seen |= MISO;
      if (i == 3) tx_valid = 1'b0;
    end
    tx_data = '0;
    checks++;
    if (miso_seen !== 1'b0) begin errors++; $display("FAIL stray_tx_miso: got %b required 0", miso_seen); end
    close_frame();
  endtask

  task automatic test_seq_cfg;
    logic exp_v;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef SPI_SLAVE_RD_SEQ_EN
    exp_v = 1'b0;
`else
    exp_v = 1'b1;
    rx_q.push_back(10'h300);
`endif
    send_bits(10'h300, FRAME_W);
    @(negedge clk);
    checks++;
    if (rx_valid !== exp_v) begin errors++; $display("FAIL seq_cfg_valid: got %b required %b", rx_valid, exp_v); end
    @(negedge clk);
    close_frame();
  endtask

  initial begin
    test_reset();
    test_write();
    test_reset_mid_frame();
    test_read_seq();
    test_abort();
    test_stray_tx();
    test_seq_cfg();
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("FAIL missing_rx_valid: got %0d words never delivered, required 0", rx_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
